link_responder: RTL and testbench

Data-source end of the 4-phase req/ack byte link: the responder in a pull transfer. An initiator FSM raises `req`; this block presents the next byte from its internal FIFO on `data`, raises `ack`, and completes the handshake when `req` falls. The FIFO is filled by a local producer through a simple write port. It sits beside the existing master/slave pair, carrying bytes in the opposite direction on the same link.

---
 rtl/link_pkg.sv | 12 +
 rtl/link_responder_if.sv | 19 +
 rtl/link_fifo.sv | 57 +++++
 rtl/link_responder.sv | 99 +++++++++
 tb/tb_link_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// link_pkg: definitions shared by the req/ack byte link blocks.
//   LINK_WIDTH   - link data width, common to the master/slave FSMs and the responder
//   link_state_e - responder handshake states
package link_pkg;
  localparam int LINK_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } link_state_e;
endpackage

// File: rtl/link_responder_if.sv
// link_responder_if: 4-phase req/ack byte link.
//   req    - initiator request
//   ack    - responder acknowledge
//   data   - byte from the responder, valid while ack=1
//   parity - even parity of data (present only when LINK_PARITY_EN is defined)
// Modports: master = initiator side, slave = responder side.
interface link_responder_if #(parameter int WIDTH = 8) ();
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] data;
`ifdef LINK_PARITY_EN
  logic             parity;
  modport master (output req, input ack, input data, input parity);
  modport slave  (input req, output ack, output data, output parity);
`else
  modport master (output req, input ack, input data);
  modport slave  (input req, output ack, output data);
`endif
endinterface

// File: rtl/link_fifo.sv
// link_fifo: circular-buffer FIFO feeding the link responder.
//   clk, rst           - clock, async active-low reset (flushes pointers/count)
//   push, push_data    - write port; dropped when full unless a pop happens too
//   pop, pop_data      - read port; pop_data is the current head (no bypass)
//   full, empty        - decoded from the count
//   overflow           - sticky: a push was refused; cleared only by reset
module link_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/link_responder.sv
// link_responder: data-source end of the 4-phase req/ack link. On req with
// data available it pops the FIFO head onto the link and raises ack; the
// handshake closes when req falls, followed by one RELEASE cycle of ack low.
//   clk, rst          - clock, async active-low reset
//   wr_en, wr_data    - local producer write port
//   full, empty       - FIFO status (combinational)
//   overflow          - sticky refused-write flag
//   lnk (slave)       - req in; ack, data (and parity) out, all registered
//   sent_count        - bytes handed off, wraps 255->0
//   stall             - registered: req pending on an empty FIFO
// Optional feature macro: LINK_PARITY_EN adds lnk.parity = ^data.
module link_responder
  import link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = LINK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  link_responder_if.slave  lnk,
  output logic [7:0]       sent_count,
  output logic             stall
);
  link_state_e      state;
  logic             ack_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] head;
  logic             pop;

  assign pop = (state == IDLE) && lnk.req && !empty;

  link_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

`ifdef LINK_PARITY_EN
  logic parity_q;
  assign lnk.parity = parity_q;
`endif

  assign lnk.ack  = ack_q;
  assign lnk.data = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ack_q      <= 1'b0;
      data_q     <= '0;
      sent_count <= '0;
      stall      <= 1'b0;
`ifdef LINK_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_q     <= head;
            ack_q      <= 1'b1;
            sent_count <= sent_count + 8'd1;
            stall      <= 1'b0;
`ifdef LINK_PARITY_EN
            parity_q   <= ^head;
`endif
            state      <= ACK;
          end else begin
            stall <= lnk.req;
          end
        end
        ACK: begin
          stall <= 1'b0;
          if (!lnk.req) begin
            ack_q <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // req is deliberately ignored here to guarantee an ack-low gap.
          stall <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_responder.sv
// tb_link_responder: directed and randomized checks of link_responder against
// a queue-based model of the FIFO contents, handshake count and overflow flag.
module tb_link_responder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, stall;
  logic [7:0] sent_count;

  link_responder_if #(.WIDTH(8)) lnk ();

  link_responder #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .lnk       (lnk),
    .sent_count(sent_count),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_sent = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag);
    chk({tag, "_full"},  32'(full),       32'(q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty),      32'(q.size() == 0));
    chk({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    chk({tag, "_sent"},  32'(sent_count), 32'(m_sent));
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_ack"},  32'(lnk.ack),    32'd1);
    chk({tag, "_data"}, 32'(lnk.data),   32'(exp));
    chk({tag, "_sent"}, 32'(sent_count), 32'(m_sent));
`ifdef LINK_PARITY_EN
    chk({tag, "_par"},  32'(lnk.parity), 32'(^exp));
`endif
  endtask

  // Full handshake with data already queued: ack must follow req by one cycle.
  task automatic hs(input string tag);
    logic [7:0] exp;
    req_set(1'b1);
    @(negedge clk);
    exp = q.pop_front();
    m_sent = m_sent + 8'd1;
    chk_byte(tag, exp);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk({tag, "_hold"}, {lnk.ack, 23'd0, lnk.data}, {1'b1, 23'd0, exp});
    end
    req_set(1'b0);
    @(negedge clk);
    chk({tag, "_fall"}, {lnk.ack, 23'd0, lnk.data}, {1'b0, 23'd0, exp});
    @(negedge clk);
  endtask

  task automatic req_set(input logic v);
    lnk.req = v;
  endtask

  initial begin
    logic [7:0] exp;
    lnk.req = 1'b0;
    #12;
    // reset values while reset is held
    chk("rst_ack", 32'(lnk.ack), 0);
    chk("rst_data", 32'(lnk.data), 0);
    chk("rst_stall", 32'(stall), 0);
    st("rst");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // two basic handshakes
    wr(8'hA5); wr(8'h3C);
    hs("t1a"); hs("t1b");
    st("t1");

    // request against an empty FIFO
    req_set(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wait", {31'd0, stall}, 1);
      chk("stall_ack", {31'd0, lnk.ack}, 0);
    end
    wr_en = 1'b1; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    chk("nobypass_ack", {31'd0, lnk.ack}, 0);
    @(negedge clk);
    m_sent = m_sent + 8'd1;
    chk_byte("stall_srv", 8'h11);
    chk("stall_clr", {31'd0, stall}, 0);
    req_set(1'b0);
    @(negedge clk);
    chk("stall_fall", {31'd0, lnk.ack}, 0);
    @(negedge clk);

    // overflow on a fifth write
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    st("fill");
    wr(8'hFF);
    st("ovf");
    for (int i = 0; i < 4; i++) hs("drain");
    st("drained");

    // ack-low gap when req is re-raised right after ack falls
    wr(8'h21); wr(8'h22);
    req_set(1'b1);
    @(negedge clk);
    exp = q.pop_front(); m_sent = m_sent + 8'd1;
    chk_byte("gap1", exp);
    req_set(1'b0);
    @(negedge clk);
    chk("gap_fall", {31'd0, lnk.ack}, 0);
    req_set(1'b1);
    @(negedge clk);
    chk("gap_release", {31'd0, lnk.ack}, 0);
    @(negedge clk);
    exp = q.pop_front(); m_sent = m_sent + 8'd1;
    chk_byte("gap2", exp);
    req_set(1'b0);
    @(negedge clk); @(negedge clk);

    // reset in the middle of a transfer
    wr(8'h5A); wr(8'h6B);
    req_set(1'b1);
    @(negedge clk);
    exp = q.pop_front(); m_sent = m_sent + 8'd1;
    chk_byte("mid", exp);
    #1 rst = 1'b0;
    #1;
    q.delete(); m_sent = '0; m_ovf = 1'b0;
    chk("mid_ack", {31'd0, lnk.ack}, 0);
    chk("mid_data", 32'(lnk.data), 0);
    st("mid");
    req_set(1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // push and pop together with the FIFO full
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    req_set(1'b1); wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    exp = q.pop_front(); q.push_back(8'h77); m_sent = m_sent + 8'd1;
    chk_byte("pp", exp);
    st("pp");
    req_set(1'b0);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) hs("pp_drain");
    st("pp_drained");

`ifdef LINK_PARITY_EN
    wr(8'h07);
    hs("par07");
`endif

    // randomized bursts of writes and handshakes
    for (int r = 0; r < 12; r++) begin
      int n, k;
      n = $urandom_range(0, 6);
      repeat (n) wr(8'($urandom));
      st("rnd_w");
      k = $urandom_range(0, q.size());
      repeat (k) hs("rnd_hs");
      st("rnd_h");
    end

    // sent_count wraps past 255
    repeat (260) begin
      wr(8'($urandom));
      hs("wrap");
    end
    st("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
